// File: rtl/adder_pipe.sv
// Pipelined add/subtract unit: the carry chain is cut into MP_STAGES equal segments,
// one segment resolved per clock, with a valid/ready handshake on both sides.
module adder_pipe #(
   parameter int MP_WIDTH  = 8,
   parameter int MP_STAGES = 2
) (
   input  logic                iclk,
   input  logic                irst,
   input  logic                ivalid,
   output logic                oready,
   input  logic [MP_WIDTH-1:0] ia,
   input  logic [MP_WIDTH-1:0] ib,
   input  logic                icin,
   input  logic                isub,
   output logic                ovalid,
   input  logic                iready,
   output logic [MP_WIDTH-1:0] osum,
   output logic                ocout,
   output logic                ooverflow
);

   localparam int SW = MP_WIDTH / MP_STAGES;

   function automatic logic [SW:0] seg_add(input logic [SW-1:0] a,
                                           input logic [SW-1:0] b,
                                           input logic          c);
      seg_add = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, c};
   endfunction

   logic                adv;
   logic [MP_WIDTH-1:0] bx0;
   logic                c0;

   // Subtraction is A + ~B + 1, so the incoming carry is forced high.
   assign bx0    = isub ? ~ib : ib;
   assign c0     = isub ? 1'b1 : icin;
   assign adv    = iready || !ovalid;
   assign oready = adv;

   for (genvar k = 0; k < MP_STAGES; k++) begin : g_stage
      logic [SW-1:0]         a_seg;
      logic [SW-1:0]         b_seg;
      logic                  c_in;
      logic                  v_in;
      logic [SW:0]           seg;
      logic [(k+1)*SW-1:0]   sum_nxt;
      logic [(k+1)*SW-1:0]   sum_p;
      logic                  cy_p;
      logic                  vld_p;

      assign seg = seg_add(a_seg, b_seg, c_in);

      if (k == 0) begin : g_in
         assign a_seg   = ia[SW-1:0];
         assign b_seg   = bx0[SW-1:0];
         assign c_in    = c0;
         assign v_in    = ivalid;
         assign sum_nxt = seg[SW-1:0];
      end else begin : g_in
         assign a_seg   = g_stage[k-1].g_hi.a_p[k*SW +: SW];
         assign b_seg   = g_stage[k-1].g_hi.bx_p[k*SW +: SW];
         assign c_in    = g_stage[k-1].cy_p;
         assign v_in    = g_stage[k-1].vld_p;
         assign sum_nxt = {seg[SW-1:0], g_stage[k-1].sum_p};
      end

      always_ff @(posedge iclk or posedge irst) begin
         if (irst)
            vld_p <= 1'b0;
         else if (adv)
            vld_p <= v_in;
      end

      // Operand bits not yet consumed travel alongside the partial sum.
      if (k < MP_STAGES - 1) begin : g_hi
         logic [MP_WIDTH-1:(k+1)*SW] a_nxt;
         logic [MP_WIDTH-1:(k+1)*SW] bx_nxt;
         logic [MP_WIDTH-1:(k+1)*SW] a_p;
         logic [MP_WIDTH-1:(k+1)*SW] bx_p;

         if (k == 0) begin : g_src
            assign a_nxt  = ia[MP_WIDTH-1:SW];
            assign bx_nxt = bx0[MP_WIDTH-1:SW];
         end else begin : g_src
            assign a_nxt  = g_stage[k-1].g_hi.a_p[MP_WIDTH-1:(k+1)*SW];
            assign bx_nxt = g_stage[k-1].g_hi.bx_p[MP_WIDTH-1:(k+1)*SW];
         end

         always_ff @(posedge iclk) begin
            if (adv) begin
               a_p  <= a_nxt;
               bx_p <= bx_nxt;
            end
         end

         always_ff @(posedge iclk) begin
            if (adv) begin
               sum_p <= sum_nxt;
               cy_p  <= seg[SW];
            end
         end
      end else begin : g_out
         logic ovf_nxt;
         logic ovf_p;

         // MSB segment lives here, so signed overflow is resolved in the final stage.
         assign ovf_nxt = (a_seg[SW-1] == b_seg[SW-1]) && (seg[SW-1] != a_seg[SW-1]);

         always_ff @(posedge iclk or posedge irst) begin
            if (irst) begin
               sum_p <= '0;
               cy_p  <= 1'b0;
               ovf_p <= 1'b0;
            end else if (adv) begin
               sum_p <= sum_nxt;
               cy_p  <= seg[SW];
               ovf_p <= ovf_nxt;
            end
         end
      end
   end

   // ---- output stage ----
   assign ovalid    = g_stage[MP_STAGES-1].vld_p;
   assign osum      = g_stage[MP_STAGES-1].sum_p;
   assign ocout     = g_stage[MP_STAGES-1].cy_p;
   assign ooverflow = g_stage[MP_STAGES-1].g_out.ovf_p;

endmodule

// File: tb/tb_adder_pipe.sv
// Directed checks of adder_pipe (8-bit, 2 stages) plus a randomised stream against
// a reference model on a 16-bit, 4-stage instance.
module tb_adder_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic       v8, rdy8, cin8, sub8;
   logic [7:0] a8, b8;
   logic       or8, ov8, co8, of8;
   logic [7:0] s8;

   logic        v16, rdy16, cin16, sub16;
   logic [15:0] a16, b16;
   logic        or16, ov16, co16, of16;
   logic [15:0] s16;

   int n_chk  = 0;
   int n_fail = 0;

   adder_pipe #(.MP_WIDTH(8), .MP_STAGES(2)) dut8 (
      .iclk(clk), .irst(rst), .ivalid(v8), .oready(or8), .ia(a8), .ib(b8),
      .icin(cin8), .isub(sub8), .ovalid(ov8), .iready(rdy8), .osum(s8),
      .ocout(co8), .ooverflow(of8)
   );

   adder_pipe #(.MP_WIDTH(16), .MP_STAGES(4)) dut16 (
      .iclk(clk), .irst(rst), .ivalid(v16), .oready(or16), .ia(a16), .ib(b16),
      .icin(cin16), .isub(sub16), .ovalid(ov16), .iready(rdy16), .osum(s16),
      .ocout(co16), .ooverflow(of16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic sub, input logic v);
      a8   = a;
      b8   = b;
      cin8 = cin;
      sub8 = sub;
      v8   = v;
   endtask

   task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic sub,
                      input logic [7:0] es, input logic ec, input logic eo);
      drive8(a, b, cin, sub, 1'b1);
      tick();
      v8 = 1'b0;
      chk({tag, ".lat"}, 32'(ov8), 0);
      tick();
      chk({tag, ".vld"}, 32'(ov8), 1);
      chk({tag, ".sum"}, 32'(s8), 32'(es));
      chk({tag, ".cout"}, 32'(co8), 32'(ec));
      chk({tag, ".ovf"}, 32'(of8), 32'(eo));
      tick();
   endtask

   function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
      logic [15:0] bx;
      logic [16:0] r;
      logic        ovf;
      bx  = sub ? ~b : b;
      r   = {1'b0, a} + {1'b0, bx} + {16'd0, (sub ? 1'b1 : cin)};
      ovf = (a[15] == bx[15]) && (r[15] != a[15]);
      return {ovf, r[16], r[15:0]};
   endfunction

   logic [7:0] st_a [4] = '{8'h10, 8'h0F, 8'hF0, 8'h55};
   logic [7:0] st_b [4] = '{8'h20, 8'h01, 8'h20, 8'hAA};
   logic       st_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   logic [7:0] st_s [4] = '{8'h30, 8'h10, 8'h10, 8'h00};
   logic       st_o [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

   logic [17:0] q [$];
   logic [17:0] exp18;
   int          sent;

   initial begin
      rst = 1'b1;
      drive8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      rdy8  = 1'b1;
      v16   = 1'b0;
      rdy16 = 1'b1;
      a16   = '0;
      b16   = '0;
      cin16 = 1'b0;
      sub16 = 1'b0;
      #1;
      chk("rst.ovalid", 32'(ov8), 0);
      chk("rst.osum", 32'(s8), 0);
      chk("rst.cout", 32'(co8), 0);
      chk("rst.ovf", 32'(of8), 0);
      chk("rst.oready", 32'(or8), 1);
      chk("rst16.ovalid", 32'(ov16), 0);
      chk("rst16.osum", 32'(s16), 0);
      tick();
      rst = 1'b0;
      tick();

      op8("add2p3",  8'h02, 8'h03, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0);
      op8("addff",   8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      op8("add7f",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      op8("segcy",   8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
      op8("sub5m7",  8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      op8("sub7m5",  8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0);
      op8("sub80m1", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

      // back-to-back stream of four adds
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive8(st_a[i], st_b[i], st_c[i], 1'b0, 1'b1);
         else       v8 = 1'b0;
         tick();
         if (i >= 1 && i <= 4) begin
            chk($sformatf("stream%0d.vld", i - 1), 32'(ov8), 1);
            chk($sformatf("stream%0d.sum", i - 1), 32'(s8), 32'(st_s[i-1]));
            chk($sformatf("stream%0d.cout", i - 1), 32'(co8), 32'(st_o[i-1]));
         end
      end
      chk("stream.end", 32'(ov8), 0);
      tick();

      // stall with the pipe full
      drive8(8'h11, 8'h22, 1'b0, 1'b0, 1'b1);
      tick();
      drive8(8'h40, 8'h41, 1'b0, 1'b0, 1'b1);
      tick();
      rdy8 = 1'b0;
      drive8(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
      #1;
      chk("stall.oready", 32'(or8), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("stall%0d.vld", i), 32'(ov8), 1);
         chk($sformatf("stall%0d.sum", i), 32'(s8), 32'h33);
         chk($sformatf("stall%0d.oready", i), 32'(or8), 0);
      end
      rdy8 = 1'b1;
      #1;
      chk("release.oready", 32'(or8), 1);
      tick();
      v8 = 1'b0;
      chk("release.y.vld", 32'(ov8), 1);
      chk("release.y.sum", 32'(s8), 32'h81);
      chk("release.y.ovf", 32'(of8), 1);
      tick();
      chk("release.z.vld", 32'(ov8), 1);
      chk("release.z.sum", 32'(s8), 32'hF0);
      chk("release.z.cout", 32'(co8), 0);
      tick();
      chk("release.empty", 32'(ov8), 0);

      // reset with two transactions in flight
      drive8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
      tick();
      drive8(8'h7F, 8'h7F, 1'b0, 1'b0, 1'b1);
      tick();
      v8 = 1'b0;
      chk("inflight.vld", 32'(ov8), 1);
      chk("inflight.sum", 32'(s8), 32'h46);
      rst = 1'b1;
      #1;
      chk("midrst.vld", 32'(ov8), 0);
      chk("midrst.sum", 32'(s8), 0);
      chk("midrst.ovf", 32'(of8), 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("postrst%0d.vld", i), 32'(ov8), 0);
      end

      // randomised stream on the wide instance with random back-pressure
      sent = 0;
      for (int cyc = 0; cyc < 8000 && (sent < 1000 || q.size() != 0); cyc++) begin
         v16   = (sent < 1000) && ($urandom_range(3) != 0);
         a16   = 16'($urandom);
         b16   = 16'($urandom);
         cin16 = 1'($urandom);
         sub16 = 1'($urandom);
         rdy16 = ($urandom_range(3) != 0);
         #1;
         if (ov16 && rdy16) begin
            if (q.size() == 0) begin
               chk("rand16.spurious", 32'(ov16), 0);
            end else begin
               exp18 = q.pop_front();
               chk("rand16.result", 32'({of16, co16, s16}), 32'(exp18));
            end
         end
         if (v16 && or16) begin
            q.push_back(model16(a16, b16, cin16, sub16));
            sent++;
         end
         tick();
      end
      chk("rand16.sent", 32'(sent), 1000);
      chk("rand16.drained", 32'(q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
